// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU FSM states and
// the funct3 legality rule used by the alignment logic.
package rv32i_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) begin
         return (f3 >= 3'b011);
      end
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: byte enables, store-data
// replication, load extraction with sign/zero extension, and access checks.
module lsu_align
   import rv32i_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  i_we,
   input  logic [2:0]            i_funct3,
   input  logic [1:0]            i_addr_lo,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DATA_W-1:0]     i_rdata,
   output logic [DATA_W/8-1:0]   o_be,
   output logic [DATA_W-1:0]     o_wdata,
   output logic [DATA_W-1:0]     o_rdata,
   output logic                  o_misalign,
   output logic                  o_illegal
);

   logic              w_illegal;
   logic [DATA_W-1:0] w_shifted;

   // Legality depends only on direction and funct3.
   always_comb begin
      w_illegal = f3_illegal(i_we, i_funct3);
   end

   // Misalignment is only meaningful for a legal size; illegal takes precedence.
   always_comb begin
      o_illegal  = w_illegal;
      o_misalign = 1'b0;
      if (!w_illegal) begin
         case (i_funct3[1:0])
            2'b01:   o_misalign = i_addr_lo[0];
            2'b10:   o_misalign = |i_addr_lo;
            default: o_misalign = 1'b0;
         endcase
      end
   end

   // Store lanes: replicate the datum across the word so memory picks it up by be.
   always_comb begin
      case (i_funct3[1:0])
         2'b00: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
         end
         default: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
         end
      endcase
   end

   // Load extract: bring the addressed byte/half down to bit 0, then extend.
   always_comb begin
      w_shifted = i_rdata >> {i_addr_lo, 3'b000};
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_BU:   o_rdata = {24'd0, w_shifted[7:0]};
         F3_HU:   o_rdata = {16'd0, w_shifted[15:0]};
         default: o_rdata = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit. Accepts one access in IDLE, traps faults
// without touching memory, otherwise runs request/grant (and for loads
// rvalid) with data memory, then pulses rsp_done for one cycle.
//
// Handshakes: the core side is accepted on the rising edge where req_valid and
// req_ready are both high (req_ready is high only in IDLE). The memory side
// holds mem_req with stable addr/we/be/wdata until a cycle with mem_gnt high;
// mem_rvalid is honoured only in the state after the grant. Grants and read
// data arriving in any other state are ignored.
module load_store_unit
   import rv32i_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_done,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_misalign,
   output logic                  rsp_illegal,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_we,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output lsu_state_t            dbg_state
);

   lsu_state_t          r_state;
   logic                r_we;
   logic [2:0]          r_funct3;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_be;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_misalign;
   logic                r_illegal;

   logic                w_sel_we;
   logic [2:0]          w_sel_funct3;
   logic [1:0]          w_sel_addr_lo;
   logic [DATA_W/8-1:0] w_be;
   logic [DATA_W-1:0]   w_lane_wdata;
   logic [DATA_W-1:0]   w_load_data;
   logic                w_misalign;
   logic                w_illegal;

   // In IDLE the checks look at the incoming request; afterwards at the latched one.
   always_comb begin
      w_sel_we      = (r_state == IDLE) ? req_we          : r_we;
      w_sel_funct3  = (r_state == IDLE) ? req_funct3      : r_funct3;
      w_sel_addr_lo = (r_state == IDLE) ? req_addr[1:0]   : r_addr[1:0];
   end

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .i_we       (w_sel_we),
      .i_funct3   (w_sel_funct3),
      .i_addr_lo  (w_sel_addr_lo),
      .i_wdata    (req_wdata),
      .i_rdata    (mem_rdata),
      .o_be       (w_be),
      .o_wdata    (w_lane_wdata),
      .o_rdata    (w_load_data),
      .o_misalign (w_misalign),
      .o_illegal  (w_illegal)
   );

   // Control FSM and all latched access/response state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_funct3   <= 3'd0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_rdata    <= '0;
         r_misalign <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_funct3   <= req_funct3;
                  r_addr     <= req_addr;
                  r_wdata    <= w_lane_wdata;
                  r_be       <= w_be;
                  r_rdata    <= '0;
                  r_misalign <= w_misalign;
                  r_illegal  <= w_illegal;
                  r_state    <= (w_misalign || w_illegal) ? RESP : REQ;
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  r_state <= r_we ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  r_rdata <= w_load_data;
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_rdata    <= '0;
               r_misalign <= 1'b0;
               r_illegal  <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Outputs decode directly from registered state; strobes only live in REQ.
   always_comb begin
      req_ready    = (r_state == IDLE);
      rsp_done     = (r_state == RESP);
      rsp_rdata    = r_rdata;
      rsp_misalign = r_misalign;
      rsp_illegal  = r_illegal;
      mem_req      = (r_state == REQ);
      mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
      mem_we       = (r_state == REQ) && r_we;
      mem_be       = (r_state == REQ) ? r_be : '0;
      mem_wdata    = r_wdata;
      dbg_state    = r_state;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads with extension, delayed
// handshakes, fault trapping and asynchronous reset mid-load.
module tb_load_store_unit;
   import rv32i_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_done;
   logic [31:0] rsp_rdata;
   logic        rsp_misalign;
   logic        rsp_illegal;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   lsu_state_t  dbg_state;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_done     (rsp_done),
      .rsp_rdata    (rsp_rdata),
      .rsp_misalign (rsp_misalign),
      .rsp_illegal  (rsp_illegal),
      .mem_req      (mem_req),
      .mem_gnt      (mem_gnt),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .dbg_state    (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Results captured by run_access
   int          res_done;
   logic [31:0] res_rdata;
   logic        res_mis;
   logic        res_ill;
   logic        res_saw_req;
   logic [31:0] res_addr;
   logic [3:0]  res_be;
   logic [31:0] res_wdata;
   logic        res_we;
   logic        res_ready_busy;
   logic [3:0]  res_resp_be;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One access: gnt arrives gnt_dly cycles after the first REQ cycle, rvalid
   // rv_dly cycles after the grant. A junk rvalid is also driven in the grant
   // cycle, which the unit must ignore. res_done is the cycle offset from accept.
   task automatic run_access(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
      int gnt_k;
      int rv_k;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      gnt_k          = 1 + gnt_dly;
      rv_k           = gnt_k + rv_dly;
      res_done       = 0;
      res_saw_req    = 1'b0;
      res_ready_busy = 1'b1;
      res_addr       = '0;
      res_be         = '0;
      res_wdata      = '0;
      res_we         = 1'b0;
      res_rdata      = '0;
      res_mis        = 1'b0;
      res_ill        = 1'b0;
      res_resp_be    = '0;
      for (int k = 1; k <= 40 && res_done == 0; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (k == 1) res_ready_busy = req_ready;
         if (mem_req === 1'b1 && !res_saw_req) begin
            res_saw_req = 1'b1;
            res_addr    = mem_addr;
            res_be      = mem_be;
            res_wdata   = mem_wdata;
            res_we      = mem_we;
         end
         if (rsp_done === 1'b1) begin
            res_done    = k;
            res_rdata   = rsp_rdata;
            res_mis     = rsp_misalign;
            res_ill     = rsp_illegal;
            res_resp_be = mem_be;
         end
         mem_gnt    = (k == gnt_k);
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
         if (k == gnt_k) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
         end
         if (k == rv_k) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
         end
      end
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   int done_seen;

   initial begin
      // Reset
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      repeat (2) @(negedge clk);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_done", 32'(rsp_done), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // SW word, immediate grant
      run_access(1'b1, F3_W, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 0, 1);
      check("sw_done_cycle", 32'(res_done), 32'd2);
      check("sw_addr", res_addr, 32'h0000_0104);
      check("sw_be", 32'(res_be), 32'hF);
      check("sw_wdata", res_wdata, 32'hDEAD_BEEF);
      check("sw_we", 32'(res_we), 32'd1);
      check("sw_ready_busy", 32'(res_ready_busy), 32'd0);
      check("sw_rdata", res_rdata, 32'd0);
      check("sw_resp_be", 32'(res_resp_be), 32'd0);

      // SB top byte
      run_access(1'b1, F3_B, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0, 1);
      check("sb_done_cycle", 32'(res_done), 32'd2);
      check("sb_addr", res_addr, 32'h0000_0100);
      check("sb_be", 32'(res_be), 32'h8);
      check("sb_wdata", res_wdata, 32'hA5A5_A5A5);

      // SH upper half, grant delayed one cycle
      run_access(1'b1, F3_H, 32'h0000_0102, 32'h1234_ABCD, 32'd0, 1, 1);
      check("sh_done_cycle", 32'(res_done), 32'd3);
      check("sh_be", 32'(res_be), 32'hC);
      check("sh_wdata", res_wdata, 32'hABCD_ABCD);

      // LB sign-extends 0x80
      run_access(1'b0, F3_B, 32'h0000_0102, 32'd0, 32'h1280_3456, 0, 1);
      check("lb_done_cycle", 32'(res_done), 32'd3);
      check("lb_rdata", res_rdata, 32'hFFFF_FF80);
      check("lb_we", 32'(res_we), 32'd0);
      check("lb_addr", res_addr, 32'h0000_0100);

      // LBU zero-extends
      run_access(1'b0, F3_BU, 32'h0000_0102, 32'd0, 32'h1280_3456, 0, 1);
      check("lbu_rdata", res_rdata, 32'h0000_0080);

      // LH with gnt delayed 2 and rvalid 3 cycles after grant
      run_access(1'b0, F3_H, 32'h0000_0102, 32'd0, 32'h1280_3456, 2, 3);
      check("lh_done_cycle", 32'(res_done), 32'd7);
      check("lh_rdata", res_rdata, 32'h0000_1280);

      // LHU lower half with top bit set, LW aligned
      run_access(1'b0, F3_HU, 32'h0000_0200, 32'd0, 32'h0000_8001, 0, 2);
      check("lhu_rdata", res_rdata, 32'h0000_8001);
      run_access(1'b0, F3_W, 32'h0000_0100, 32'd0, 32'h1280_3456, 0, 1);
      check("lw_rdata", res_rdata, 32'h1280_3456);

      // LW misaligned: no memory traffic
      run_access(1'b0, F3_W, 32'h0000_0102, 32'd0, 32'h1111_1111, 0, 1);
      check("lw_mis_done_cycle", 32'(res_done), 32'd1);
      check("lw_mis_flag", 32'(res_mis), 32'd1);
      check("lw_mis_ill", 32'(res_ill), 32'd0);
      check("lw_mis_no_req", 32'(res_saw_req), 32'd0);
      check("lw_mis_rdata", res_rdata, 32'd0);

      // SH odd address misaligned
      run_access(1'b1, F3_H, 32'h0000_0101, 32'h0000_FFFF, 32'd0, 0, 1);
      check("sh_mis_flag", 32'(res_mis), 32'd1);
      check("sh_mis_no_req", 32'(res_saw_req), 32'd0);

      // Illegal load funct3 011 and store funct3 100
      run_access(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 0, 1);
      check("ld_ill_done_cycle", 32'(res_done), 32'd1);
      check("ld_ill_flag", 32'(res_ill), 32'd1);
      check("ld_ill_no_req", 32'(res_saw_req), 32'd0);
      run_access(1'b1, 3'b100, 32'h0000_0100, 32'd0, 32'd0, 0, 1);
      check("st_ill_flag", 32'(res_ill), 32'd1);
      check("st_ill_mis", 32'(res_mis), 32'd0);

      // Reset asserted while waiting for load data
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = F3_W;
      req_addr   = 32'h0000_0200;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("rstw_in_wait", 32'(dbg_state), 32'(WAIT));
      #2 rst = 1'b0;
      #1;
      check("rstw_mem_req", 32'(mem_req), 32'd0);
      check("rstw_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = (k < 3);
         mem_rdata  = 32'hCAFE_F00D;
         @(negedge clk);
         if (rsp_done === 1'b1) done_seen++;
      end
      mem_rvalid = 1'b0;
      check("rstw_no_done", 32'(done_seen), 32'd0);
      check("rstw_state", 32'(dbg_state), 32'(IDLE));
      check("rstw_rdata", rsp_rdata, 32'd0);
      check("rstw_mem_addr", mem_addr, 32'd0);
      check("rstw_mem_be", 32'(mem_be), 32'd0);
      check("rstw_flags", {30'd0, rsp_misalign, rsp_illegal}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
